// File: rtl/loteria_ticket_driver.sv
// Plays a 5-digit BCD ticket into the lottery checker: clear, five digit strobes, finish, sample prize.
// Optional LOTERIA_DRV_STATS_EN adds saturating tickets_played / wins counters.
module loteria_ticket_driver #(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned RESULT_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [19:0] ticket,
    output logic        busy,
    output logic        done,
    output logic [1:0]  prize,
    output logic        error,
    output logic        chk_reset,
    output logic [3:0]  chk_num,
    output logic        chk_insert,
    output logic        chk_finish,
    input  logic [1:0]  chk_prm
`ifdef LOTERIA_DRV_STATS_EN
    ,
    output logic [7:0]  tickets_played,
    output logic [7:0]  wins
`endif
);

    localparam int unsigned CMAX = (GAP_CYCLES > RESULT_WAIT) ?
                                   ((GAP_CYCLES > 2) ? GAP_CYCLES : 2) :
                                   ((RESULT_WAIT > 2) ? RESULT_WAIT : 2);
    localparam int unsigned CW = $clog2(CMAX);

    typedef enum logic [2:0] {
        S_IDLE, S_REJ, S_CLR, S_SEND, S_GAP, S_FIN, S_WAIT, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [19:0]     ticket_q, ticket_n;
    logic [2:0]      idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      prize_n;
    logic            error_n;
    logic [3:0]      num_n;
    logic            clr_q;
    logic            bad_digit;

    function automatic logic [3:0] digit_of(input logic [19:0] t, input logic [2:0] i);
        case (i)
            3'd0:    digit_of = t[19:16];
            3'd1:    digit_of = t[15:12];
            3'd2:    digit_of = t[11:8];
            3'd3:    digit_of = t[7:4];
            default: digit_of = t[3:0];
        endcase
    endfunction

    // Next-state and next register values; outputs are registered from state_n
    always_comb begin
        state_n   = state;
        ticket_n  = ticket_q;
        idx_n     = idx;
        cnt_n     = cnt;
        prize_n   = prize;
        error_n   = error;
        num_n     = chk_num;
        bad_digit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ticket[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (start) begin
                    ticket_n = ticket;
                    prize_n  = 2'd0;
                    error_n  = bad_digit;
                    state_n  = bad_digit ? S_REJ : S_CLR;
                end
            end
            S_REJ: state_n = S_IDLE;
            S_CLR: begin
                idx_n   = 3'd0;
                num_n   = digit_of(ticket_q, 3'd0);
                state_n = S_SEND;
            end
            S_SEND, S_GAP: begin
                if (state == S_SEND && GAP_CYCLES != 0) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else if (state == S_GAP && cnt != CW'(GAP_CYCLES - 1)) begin
                    cnt_n = CW'(cnt + 1'b1);
                end else if (idx == 3'd4) begin
                    state_n = S_FIN;
                end else begin
                    idx_n   = 3'(idx + 3'd1);
                    num_n   = digit_of(ticket_q, 3'(idx + 3'd1));
                    state_n = S_SEND;
                end
            end
            S_FIN: begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == CW'(RESULT_WAIT - 1)) begin
                    prize_n = chk_prm;
                    state_n = S_DONE;
                end else begin
                    cnt_n = CW'(cnt + 1'b1);
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ticket_q   <= '0;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            prize      <= '0;
            error      <= 1'b0;
            chk_num    <= '0;
            chk_insert <= 1'b0;
            chk_finish <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state      <= state_n;
            ticket_q   <= ticket_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            busy       <= (state_n != S_IDLE);
            done       <= (state_n == S_DONE) || (state_n == S_REJ);
            prize      <= prize_n;
            error      <= error_n;
            chk_num    <= num_n;
            chk_insert <= (state_n == S_SEND);
            chk_finish <= (state_n == S_FIN);
            clr_q      <= (state_n == S_CLR);
        end
    end

    assign chk_reset = reset | clr_q;

`ifdef LOTERIA_DRV_STATS_EN
    // Counts land in the same cycle as the done pulse of a played ticket
    always_ff @(posedge clk) begin
        if (reset) begin
            tickets_played <= '0;
            wins           <= '0;
        end else if (state_n == S_DONE) begin
            if (tickets_played != 8'hFF) tickets_played <= 8'(tickets_played + 8'd1);
            if (prize_n != 2'd0 && wins != 8'hFF) wins <= 8'(wins + 8'd1);
        end
    end
`endif

endmodule

// File: tb/tb_loteria_ticket_driver.sv
// Bench for loteria_ticket_driver: behavioural checker stand-in plus directed and random tickets.
module tb_loteria_ticket_driver;
    localparam int GAP  = 2;
    localparam int RW   = 3;
    localparam int N_OK = 1 + 5 * (1 + GAP) + 1 + RW + 1;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [19:0] ticket;
    logic        busy, done, error, chk_reset, chk_insert, chk_finish;
    logic [1:0]  prize, chk_prm;
    logic [3:0]  chk_num;
`ifdef LOTERIA_DRV_STATS_EN
    logic [7:0]  tickets_played, wins;
    int          exp_played = 0, exp_wins = 0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    loteria_ticket_driver #(.GAP_CYCLES(GAP), .RESULT_WAIT(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .ticket(ticket),
        .busy(busy), .done(done), .prize(prize), .error(error),
        .chk_reset(chk_reset), .chk_num(chk_num), .chk_insert(chk_insert),
        .chk_finish(chk_finish), .chk_prm(chk_prm)
`ifdef LOTERIA_DRV_STATS_EN
        , .tickets_played(tickets_played), .wins(wins)
`endif
    );

    // Checker stand-in: shifts in digits, answers one cycle after the finish strobe
    logic [19:0] chk_acc;
    logic        chk_pend;
    always @(posedge clk) begin
        if (chk_reset) begin
            chk_acc  <= '0;
            chk_pend <= 1'b0;
            chk_prm  <= '0;
        end else begin
            if (chk_insert) chk_acc <= {chk_acc[15:0], chk_num};
            chk_pend <= chk_finish;
            if (chk_pend) begin
                if (chk_acc == 20'h50967)            chk_prm <= 2'd1;
                else if (chk_acc[11:0] == 12'h967)   chk_prm <= 2'd2;
                else if (chk_acc[7:0] == 8'h67)      chk_prm <= 2'd3;
                else                                 chk_prm <= 2'd0;
            end
        end
    end

    // Interface monitor
    int         cyc = 0, n_ins = 0, n_fin = 0, n_clr = 0, n_done = 0;
    logic [3:0] dig_log [0:4095];
    int         ins_log [0:4095];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (chk_insert) begin
            dig_log[n_ins % 4096] <= chk_num;
            ins_log[n_ins % 4096] <= cyc;
            n_ins <= n_ins + 1;
        end
        if (chk_finish) n_fin <= n_fin + 1;
        if (chk_reset && !reset) n_clr <= n_clr + 1;
        if (done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int digit_k(input logic [19:0] t, input int k);
        return int'((t >> (4 * (4 - k))) & 20'hF);
    endfunction

    function automatic bit valid_ticket(input logic [19:0] t);
        for (int k = 0; k < 5; k++) if (digit_k(t, k) > 9) return 1'b0;
        return 1'b1;
    endfunction

    // Reference prize from the decimal value of the ticket
    function automatic int ref_prize(input logic [19:0] t);
        int v = 0;
        for (int k = 0; k < 5; k++) v = v * 10 + digit_k(t, k);
        if (v == 50967)       return 1;
        if (v % 1000 == 967)  return 2;
        if (v % 100 == 67)    return 3;
        return 0;
    endfunction

    // Launch one ticket at the current negedge and check the whole transaction
    task automatic play(input logic [19:0] t, input bit hold, input string tag);
        int  c, s_ins, s_fin, s_clr, s_done, ep;
        bit  ok;
        ok = valid_ticket(t);
        ep = ok ? ref_prize(t) : 0;
        ticket = t;
        start  = 1'b1;
        s_ins = n_ins; s_fin = n_fin; s_clr = n_clr; s_done = n_done;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'(1));
        check({tag, ".prize_clr"}, 32'(prize), 32'(0));
        c = 1;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
        end
        check({tag, ".latency"}, 32'(c), ok ? 32'(N_OK) : 32'(1));
        check({tag, ".prize"}, 32'(prize), 32'(ep));
        check({tag, ".error"}, 32'(error), 32'(!ok));
`ifdef LOTERIA_DRV_STATS_EN
        if (ok) begin
            if (exp_played < 255) exp_played++;
            if (ep != 0 && exp_wins < 255) exp_wins++;
        end
        check({tag, ".played"}, 32'(tickets_played), 32'(exp_played));
        check({tag, ".wins"}, 32'(wins), 32'(exp_wins));
`endif
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'(0));
        check({tag, ".ndone"}, 32'(n_done - s_done), 32'(1));
        check({tag, ".ninsert"}, 32'(n_ins - s_ins), ok ? 32'(5) : 32'(0));
        check({tag, ".nfinish"}, 32'(n_fin - s_fin), ok ? 32'(1) : 32'(0));
        check({tag, ".nclr"}, 32'(n_clr - s_clr), ok ? 32'(1) : 32'(0));
        if (ok && n_ins - s_ins == 5) begin
            for (int k = 0; k < 5; k++) begin
                check({tag, ".digit"}, 32'(dig_log[(s_ins + k) % 4096]), 32'(digit_k(t, k)));
                if (k > 0)
                    check({tag, ".spacing"},
                          32'(ins_log[(s_ins + k) % 4096] - ins_log[(s_ins + k - 1) % 4096]),
                          32'(1 + GAP));
            end
        end
    endtask

    initial begin
        int          c, s_ins, s_done;
        logic [19:0] t;
        reset = 1'b1; start = 1'b0; ticket = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.prize", 32'(prize), 0);
        check("rst.error", 32'(error), 0);
        check("rst.insert", 32'(chk_insert), 0);
        check("rst.finish", 32'(chk_finish), 0);
        check("rst.num", 32'(chk_num), 0);
        check("rst.chk_reset", 32'(chk_reset), 1);
        reset = 1'b0;
        @(negedge clk);
        check("idle.chk_reset", 32'(chk_reset), 0);

        play(20'h50967, 1'b0, "t50967");
        play(20'h12967, 1'b1, "t12967");
        check("b2b.idle", 32'(busy), 0);
        play(20'h50900, 1'b0, "t50900");
        play(20'h5A967, 1'b0, "reject");

        // Extra start pulses and ticket changes mid-run must be ignored
        ticket = 20'h50967; start = 1'b1;
        s_ins = n_ins; s_done = n_done;
        @(negedge clk);
        start = 1'b0; c = 1;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
            start  = (c == 5 || c == 15);
            if (c == 3) ticket = 20'h11111;
        end
        start = 1'b0;
        check("ign.latency", 32'(c), 32'(N_OK));
        check("ign.prize", 32'(prize), 1);
        @(negedge clk);
        check("ign.ninsert", 32'(n_ins - s_ins), 5);
        check("ign.ndone", 32'(n_done - s_done), 1);
        repeat (3) @(negedge clk);
        check("ign.idle", 32'(busy), 0);
`ifdef LOTERIA_DRV_STATS_EN
        if (exp_played < 255) exp_played++;
        if (exp_wins < 255) exp_wins++;
`endif

        // Reset in cycle 8 of a ticket
        ticket = 20'h12967; start = 1'b1;
        s_done = n_done;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid.chk_reset", 32'(chk_reset), 1);
        @(negedge clk);
        reset = 1'b0;
        check("mid.busy", 32'(busy), 0);
        check("mid.prize", 32'(prize), 0);
        check("mid.error", 32'(error), 0);
        repeat (25) @(negedge clk);
        check("mid.nodone", 32'(n_done - s_done), 0);
`ifdef LOTERIA_DRV_STATS_EN
        exp_played = 0; exp_wins = 0;
        check("mid.played", 32'(tickets_played), 0);
`endif
        play(20'h50967, 1'b0, "after_rst");

        // Random tickets: mix of plain, winning-suffix and invalid-digit cases
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < 5; k++) t = {t[15:0], 4'($urandom_range(0, 9))};
            case ($urandom_range(0, 7))
                0: t = 20'h50967;
                1: t[11:0] = 12'h967;
                2: t[7:0] = 8'h67;
                3: t[4 * $urandom_range(0, 4) +: 4] = 4'($urandom_range(10, 15));
                default: ;
            endcase
            play(t, 1'($urandom_range(0, 1)), "rand");
        end

`ifdef LOTERIA_DRV_STATS_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_played = 0; exp_wins = 0;
        play(20'h50967, 1'b0, "st1");
        play(20'h50900, 1'b0, "st2");
        play(20'h12967, 1'b0, "st3");
        play(20'hB0967, 1'b0, "st4");
        check("stats.played", 32'(tickets_played), 3);
        check("stats.wins", 32'(wins), 2);
        for (int i = 0; i < 300; i++) play(20'h50967, 1'b1, "sat");
        start = 1'b0;
        check("sat.wins", 32'(wins), 255);
        check("sat.played", 32'(tickets_played), 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/loteria_ticket_driver.md
Name: loteria_ticket_driver

Overview:
- Initiator side of the lottery checker's player interface: takes a 5-digit BCD ticket and plays it into the checker.
- Sequence: reset the checker, pulse `chk_insert` once per digit, pulse `chk_finish`, wait for the result, then sample `chk_prm`.
- Sits between a ticket source (host/FSM/switches) and the checker. Replaces manual `insert`/`finish` pushbuttons in automated runs.

Parameters:
- GAP_CYCLES, 2: idle cycles with `chk_insert` low after each digit pulse (0 allowed).
- RESULT_WAIT, 3: cycles between the `chk_finish` pulse and sampling `chk_prm` (minimum 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request to play `ticket`; sampled only in IDLE
- ticket  in  20  digit0 = [19:16] (sent first) … digit4 = [3:0]; captured when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of a ticket (played or rejected)
- prize  out  2  last sampled `chk_prm`; valid from `done`, held until the next accepted start
- error  out  1  set with `done` if any ticket digit > 9; held until the next accepted start
- chk_reset  out  1  checker reset = `reset` OR (state == CLR)
- chk_num  out  4  digit presented to the checker
- chk_insert  out  1  one-cycle digit strobe
- chk_finish  out  1  one-cycle finish strobe
- chk_prm  in  2  checker prize output

Behaviour:
- Reset values: busy, done, error, chk_insert, chk_finish = 0; prize = 0; chk_num = 0; state = IDLE; digit index = 0. `chk_reset` = 1 while `reset` is high.
- All outputs except `chk_reset` are registered or decoded from registered state. No combinational path from start/ticket to the chk_* outputs.
- States:
  - IDLE: on start=1, capture ticket; clear prize and error.
    - Any digit > 9 → REJ.
    - Otherwise → CLR.
  - REJ (1 cycle): done=1, error=1 → IDLE. No chk_* strobes are issued.
  - CLR (1 cycle): chk_reset=1; digit index := 0 → SEND.
  - SEND (1 cycle): chk_num = digit[index], chk_insert=1 → GAP if GAP_CYCLES>0, else NEXT decision taken immediately.
  - GAP (GAP_CYCLES cycles): chk_insert=0, chk_num held.
    - At end: if index==4 → FIN.
    - Else index+1 → SEND.
  - FIN (1 cycle): chk_finish=1; wait counter := 0 → WAIT.
  - WAIT (RESULT_WAIT cycles) → DONE.
  - DONE (1 cycle): prize := chk_prm; done=1 → IDLE.
- Latency: `done` is high in cycle N after the edge that accepts start, with N = 1 + 5·(1+GAP_CYCLES) + 1 + RESULT_WAIT + 1. Default N = 21. A rejected ticket gives N = 1.
- start while busy: ignored, no queueing. start held high in IDLE launches back-to-back tickets; the next ticket is accepted in the cycle after DONE.
- Counter widths: 3-bit digit index; gap and wait counters sized by $clog2 of max(GAP_CYCLES, RESULT_WAIT, 2). Counters never wrap mid-state.
- Reset mid-operation: returns to IDLE the next edge. No done pulse. Prize/error cleared. The checker is reset through `chk_reset`.
- ticket changing after acceptance has no effect.

Optional Feature:
- LOTERIA_DRV_STATS_EN defined: adds outputs `tickets_played[7:0]` and `wins[7:0]`.
  - `tickets_played` increments on every done with error=0.
  - `wins` increments when that done carries prize != 0.
  - Both saturate at 255, clear on reset, and update in the same cycle as done. Rejected tickets are not counted.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Ticket 0x50967, defaults → chk_reset pulse, then chk_num 5,0,9,6,7 with chk_insert pulses 3 cycles apart, then chk_finish. done at cycle 21 after start with prize=1, error=0.
- Ticket 0x12967 → prize=2. Ticket 0x50900 → prize=0. Both run back-to-back with start held high; the second is accepted the cycle after the first done.
- Ticket 0x5A967 → done at cycle 1 with error=1, prize=0, zero chk_insert/chk_finish/chk_reset pulses.
- start pulsed again at cycles 5 and 15 of a ticket → ignored; exactly 5 chk_insert pulses and 1 done.
- reset asserted at cycle 8 of a ticket → busy=0 next cycle, chk_reset high with reset, no done; a fresh ticket 0x50967 afterwards returns prize=1.
- With LOTERIA_DRV_STATS_EN defined: 3 tickets (prize 1, 0, 2) plus 1 invalid → tickets_played=3, wins=2. 300 winning tickets → wins saturates at 255.
